// File: rtl/mem7489_ctrl.sv
// mem7489_ctrl: sequencer for a 16x4 cell array with one-hot row select,
// a write strobe and active-low wired-AND column outputs.
// Every array-facing output comes straight from a flop, so the array
// sees clean, glitch-free selects and strobes.
module mem7489_ctrl #(
    parameter int WR_PULSE  = 2,
    parameter int RD_SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [3:0]  wdata,
    output logic        ack,
    output logic        busy,
    output logic [3:0]  rdata,
    output logic [15:0] mem_sel,
    output logic        mem_wri,
    output logic [3:0]  mem_di,
    input  logic [3:0]  mem_do
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        READ,
        DONE
    } state_t;

    // The counter counts down to zero, so it is loaded with the number of
    // cycles minus one.
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  wdata_q, wdata_d;

    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [3:0]  rdata_q, rdata_d;
    logic [15:0] sel_q, sel_d;
    logic        wri_q, wri_d;
    logic [3:0]  di_q, di_d;

    // State, cycle counter and the request fields captured at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: accept in IDLE only, then step through the fixed phase sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            SETUP: begin
                if (we_q) begin
                    state_d = WRITE;
                    cnt_d   = WR_LOAD;
                end else begin
                    state_d = READ;
                    cnt_d   = RD_LOAD;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up with the state they belong to.
    always_comb begin
        ack_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        sel_d   = 16'd0;
        wri_d   = 1'b0;
        di_d    = 4'd0;
        rdata_d = rdata_q;
        case (state_d)
            SETUP, WRITE, HOLD: begin
                sel_d = 16'b1 << addr_d;
                di_d  = we_d ? wdata_d : 4'd0;
                wri_d = (state_d == WRITE);
            end
            READ: begin
                sel_d = 16'b1 << addr_d;
            end
            DONE: begin
                ack_d = 1'b1;
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
        if ((state_q == READ) && (cnt_q == 4'd0)) begin
            rdata_d = ~mem_do;
        end
    end

    // Output flops; reset drops select and strobe immediately and clears the read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 4'd0;
            sel_q   <= 16'd0;
            wri_q   <= 1'b0;
            di_q    <= 4'd0;
        end else begin
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            wri_q   <= wri_d;
            di_q    <= di_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign rdata   = rdata_q;
    assign mem_sel = sel_q;
    assign mem_wri = wri_q;
    assign mem_di  = di_q;

endmodule

// File: tb/tb_mem7489_ctrl.sv
// tb_mem7489_ctrl: scoreboard bench for mem7489_ctrl with behavioural 16x4
// cell arrays driving active-low wired-AND column outputs.
module tb_mem7489_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, req2, we;
    logic [3:0]  addr, wdata;
    logic        ack, busy, mem_wri;
    logic [3:0]  rdata, mem_di, mem_do;
    logic [15:0] mem_sel;
    logic        ack2, busy2, mem_wri2;
    logic [3:0]  rdata2, mem_di2, mem_do2;
    logic [15:0] mem_sel2;

    logic        forceDo;
    logic [3:0]  forceVal;
    logic [3:0]  doA, doB;
    logic [3:0]  cellA [16];
    logic [3:0]  cellB [16];
    logic [3:0]  expMem [16];
    logic [3:0]  lastRd;

    typedef struct {
        int         unit;
        logic       isRead;
        logic [3:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    logic [15:0] hSel  [0:47];
    logic        hWri  [0:47];
    logic [3:0]  hDi   [0:47];
    logic        hAck  [0:47];
    logic        hBusy [0:47];

    mem7489_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .busy(busy), .rdata(rdata), .mem_sel(mem_sel),
        .mem_wri(mem_wri), .mem_di(mem_di), .mem_do(mem_do)
    );

    mem7489_ctrl #(.WR_PULSE(1), .RD_SETTLE(3)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack2), .busy(busy2), .rdata(rdata2), .mem_sel(mem_sel2),
        .mem_wri(mem_wri2), .mem_di(mem_di2), .mem_do(mem_do2)
    );

    // Cell arrays: every selected row takes mem_di while the strobe is high.
    always @(posedge clk) begin
        if (mem_wri) for (int i = 0; i < 16; i++) if (mem_sel[i]) cellA[i] <= mem_di;
        if (mem_wri2) for (int i = 0; i < 16; i++) if (mem_sel2[i]) cellB[i] <= mem_di2;
    end

    // Column outputs: a selected cell pulls down with ~Q, unselected rows read 1.
    always_comb begin
        doA = 4'hF;
        doB = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (mem_sel[i]) doA = doA & ~cellA[i];
            if (mem_sel2[i]) doB = doB & ~cellB[i];
        end
    end

    assign mem_do  = forceDo ? forceVal : doA;
    assign mem_do2 = doB;

    task automatic recordCycle(input int u, input int k);
        hSel[k]  = (u == 0) ? mem_sel : mem_sel2;
        hWri[k]  = (u == 0) ? mem_wri : mem_wri2;
        hDi[k]   = (u == 0) ? mem_di : mem_di2;
        hAck[k]  = (u == 0) ? ack : ack2;
        hBusy[k] = (u == 0) ? busy : busy2;
    endtask

    // Drives one request, scrambles the inputs after acceptance, and records cycles up to ack.
    task automatic runTxn(input int u, input logic w, input logic [3:0] a, input logic [3:0] d,
                          output int ackCyc);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (u == 0) req = 1'b1; else req2 = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; req2 = 1'b0;
        we = 1'($urandom); addr = 4'($urandom); wdata = 4'($urandom);
        ackCyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            recordCycle(u, k);
            if (hAck[k]) begin
                ackCyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = 4'd0; wdata = 4'd0;
        forceDo = 1'b0; forceVal = 4'd0; lastRd = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %0h want 0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
        total++; if (mem_sel !== 16'h0) begin bad++; $display("FAIL rst_sel: got %h want 0000", mem_sel); end
        total++; if (mem_wri !== 1'b0) begin bad++; $display("FAIL rst_wri: got %0h want 0", mem_wri); end
        total++; if (mem_di !== 4'h0) begin bad++; $display("FAIL rst_di: got %h want 0", mem_di); end
        total++; if (rdata !== 4'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy2: got %0h want 0", busy2); end
        req = 1'b1; we = 1'b1; addr = 4'd7; wdata = 4'd1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_over_req_busy: got %0h want 0", busy); end
        total++; if (mem_sel !== 16'h0) begin bad++; $display("FAIL rst_over_req_sel: got %h want 0000", mem_sel); end
        req = 1'b0; reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_req_not_queued: got %0h want 0", busy); end
    endtask

    task automatic test_write_read;
        exp_t e;
        int c;
        logic [3:0] pa [3];
        logic [3:0] pd [3];
        expMem[5] = 4'hA;
        sb.push_back('{unit: 0, isRead: 1'b0, data: 4'hA, cyc: 5});
        runTxn(0, 1'b1, 4'd5, 4'hA, c);
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL wr_ack_cycle: got %0d want %0d", c, e.cyc); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (hSel[k] !== 16'h0020) begin bad++; $display("FAIL wr_sel c%0d: got %h want 0020", k, hSel[k]); end
            total++; if (hDi[k] !== 4'hA) begin bad++; $display("FAIL wr_di c%0d: got %h want a", k, hDi[k]); end
            total++; if (hWri[k] !== ((k == 2) || (k == 3))) begin bad++; $display("FAIL wr_wri c%0d: got %0h", k, hWri[k]); end
            total++; if (hBusy[k] !== 1'b1 || hAck[k] !== 1'b0) begin bad++; $display("FAIL wr_busy_ack c%0d: got busy=%0h ack=%0h want 1/0", k, hBusy[k], hAck[k]); end
        end
        if (c == 5) begin
            total++; if (hSel[5] !== 16'h0 || hWri[5] !== 1'b0 || hDi[5] !== 4'h0) begin bad++; $display("FAIL wr_done_zero: got sel=%h wri=%0h di=%h want 0", hSel[5], hWri[5], hDi[5]); end
            total++; if (hBusy[5] !== 1'b1) begin bad++; $display("FAIL wr_done_busy: got %0h want 1", hBusy[5]); end
        end
        total++; if (rdata !== lastRd) begin bad++; $display("FAIL rdata_kept_on_write: got %h want %h", rdata, lastRd); end

        sb.push_back('{unit: 0, isRead: 1'b1, data: expMem[5], cyc: 4});
        runTxn(0, 1'b0, 4'd5, 4'h0, c);
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL rd_ack_cycle: got %0d want %0d", c, e.cyc); end
        total++; if (rdata !== e.data) begin bad++; $display("FAIL rd_data: got %h want %h", rdata, e.data); end
        lastRd = e.data;
        for (int k = 1; k <= 3; k++) begin
            total++; if (hWri[k] !== 1'b0 || hSel[k] !== 16'h0020 || hDi[k] !== 4'h0) begin bad++; $display("FAIL rd_wave c%0d: got sel=%h wri=%0h di=%h", k, hSel[k], hWri[k], hDi[k]); end
        end

        pa = '{4'd3, 4'd12, 4'd10};
        pd = '{4'h5, 4'hC, 4'h6};
        for (int i = 0; i < 3; i++) begin
            expMem[pa[i]] = pd[i];
            sb.push_back('{unit: 0, isRead: 1'b0, data: pd[i], cyc: 5});
            runTxn(0, 1'b1, pa[i], pd[i], c);
            e = sb.pop_front();
            total++; if (c !== e.cyc) begin bad++; $display("FAIL wr%0d_ack_cycle: got %0d want %0d", i, c, e.cyc); end
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{unit: 0, isRead: 1'b1, data: expMem[pa[i]], cyc: 4});
            runTxn(0, 1'b0, pa[i], 4'h0, c);
            e = sb.pop_front();
            total++; if (c !== e.cyc) begin bad++; $display("FAIL rd%0d_ack_cycle: got %0d want %0d", i, c, e.cyc); end
            total++; if (rdata !== e.data) begin bad++; $display("FAIL rd%0d_data: got %h want %h", i, rdata, e.data); end
            lastRd = e.data;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int c;
        logic [15:0] expSel;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 4'h3;
        expMem[0] = 4'h3;
        expMem[15] = 4'h6;
        sb.push_back('{unit: 0, isRead: 1'b0, data: 4'h3, cyc: 5});
        sb.push_back('{unit: 0, isRead: 1'b0, data: 4'h6, cyc: 11});
        @(posedge clk);
        #1;
        addr = 4'd15; wdata = 4'h6;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            recordCycle(0, k);
            if (hAck[k] && sb.size() > 0) begin
                e = sb.pop_front();
                total++; if (k !== e.cyc) begin bad++; $display("FAIL b2b_ack_cycle: got %0d want %0d", k, e.cyc); end
            end
            if (k == 6) begin
                @(posedge clk);
                #1;
                req = 1'b0;
            end
        end
        req = 1'b0;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL b2b_acks_missing: got %0d pending want 0", sb.size()); end
        sb.delete();
        for (int k = 1; k <= 11; k++) begin
            expSel = (k <= 4) ? 16'h0001 : ((k >= 7 && k <= 10) ? 16'h8000 : 16'h0000);
            total++; if (hSel[k] !== expSel) begin bad++; $display("FAIL b2b_sel c%0d: got %h want %h", k, hSel[k], expSel); end
        end
        total++; if (hBusy[6] !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got busy=%0h want 0", hBusy[6]); end
        total++; if (rdata !== lastRd) begin bad++; $display("FAIL b2b_rdata_kept: got %h want %h", rdata, lastRd); end
        for (int i = 0; i < 2; i++) begin
            logic [3:0] a;
            a = (i == 0) ? 4'd0 : 4'd15;
            sb.push_back('{unit: 0, isRead: 1'b1, data: expMem[a], cyc: 4});
            runTxn(0, 1'b0, a, 4'h0, c);
            e = sb.pop_front();
            total++; if (c !== e.cyc || rdata !== e.data) begin bad++; $display("FAIL b2b_readback a%0d: got cyc=%0d data=%h want cyc=%0d data=%h", a, c, rdata, e.cyc, e.data); end
            lastRd = e.data;
        end
    endtask

    task automatic test_reset_mid_write;
        exp_t e;
        int c;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd9; wdata = 4'h7;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++; if (mem_wri !== 1'b1) begin bad++; $display("FAIL midrst_wri_before: got %0h want 1", mem_wri); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_wri !== 1'b0) begin bad++; $display("FAIL midrst_wri: got %0h want 0", mem_wri); end
        total++; if (mem_sel !== 16'h0) begin bad++; $display("FAIL midrst_sel: got %h want 0000", mem_sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0h want 0", busy); end
        total++; if (rdata !== 4'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
        total++; if (mem_di !== 4'h0 || ack !== 1'b0) begin bad++; $display("FAIL midrst_di_ack: got di=%h ack=%0h want 0", mem_di, ack); end
        lastRd = 4'h0;
        sb.push_back('{unit: 0, isRead: 1'b1, data: expMem[5], cyc: 4});
        runTxn(0, 1'b0, 4'd5, 4'h0, c);
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL midrst_read_ack: got %0d want %0d", c, e.cyc); end
        total++; if (rdata !== e.data) begin bad++; $display("FAIL midrst_read_data: got %h want %h", rdata, e.data); end
        lastRd = e.data;
    endtask

    task automatic test_read_forced;
        exp_t e;
        int c;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'd12; wdata = 4'h0;
        forceDo = 1'b1; forceVal = 4'b0101;
        sb.push_back('{unit: 0, isRead: 1'b1, data: 4'b1010, cyc: 4});
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b1; addr = 4'd3;
        c = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            recordCycle(0, k);
            if (hAck[k]) begin
                c = k;
                break;
            end
            if (k == 1) req = 1'b1;
            if (k == 3) req = 1'b0;
        end
        req = 1'b0;
        forceDo = 1'b0;
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL forced_ack_cycle: got %0d want %0d", c, e.cyc); end
        total++; if (rdata !== e.data) begin bad++; $display("FAIL forced_rdata: got %b want %b", rdata, e.data); end
        lastRd = e.data;
        @(negedge clk);
        total++; if (busy !== 1'b0 || mem_sel !== 16'h0) begin bad++; $display("FAIL busy_req_ignored: got busy=%0h sel=%h want 0", busy, mem_sel); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_req_not_queued: got %0h want 0", busy); end
    endtask

    task automatic test_params;
        exp_t e;
        int c;
        int wriCount;
        sb.push_back('{unit: 1, isRead: 1'b0, data: 4'h9, cyc: 4});
        runTxn(1, 1'b1, 4'd6, 4'h9, c);
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL p_wr_ack_cycle: got %0d want %0d", c, e.cyc); end
        wriCount = 0;
        for (int k = 1; k <= 4; k++) if (hWri[k] === 1'b1) wriCount++;
        total++; if (wriCount !== 1 || hWri[2] !== 1'b1) begin bad++; $display("FAIL p_wri_width: got %0d cycles (c2=%0h) want 1", wriCount, hWri[2]); end
        total++; if (hSel[3] !== 16'h0040 || hDi[3] !== 4'h9) begin bad++; $display("FAIL p_hold: got sel=%h di=%h want 0040/9", hSel[3], hDi[3]); end
        sb.push_back('{unit: 1, isRead: 1'b1, data: 4'h9, cyc: 5});
        runTxn(1, 1'b0, 4'd6, 4'h0, c);
        e = sb.pop_front();
        total++; if (c !== e.cyc) begin bad++; $display("FAIL p_rd_ack_cycle: got %0d want %0d", c, e.cyc); end
        total++; if (rdata2 !== e.data) begin bad++; $display("FAIL p_rd_data: got %h want %h", rdata2, e.data); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_mid_write();
        test_read_forced();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem7489_ctrl.md
MEM7489_CTRL -- requirements
Module: mem7489_ctrl

Interface
REQ-001 Parameter WR_PULSE, default 2, number of cycles mem_wri is held high per write (legal 1..15).
REQ-002 Parameter RD_SETTLE, default 2, number of cycles mem_sel is held before read capture (legal 1..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  transaction request, sampled only in IDLE.
REQ-006 we  in  1  1 = write, 0 = read; latched with req.
REQ-007 addr  in  4  word address 0..15; latched with req.
REQ-008 wdata  in  4  write data; latched with req.
REQ-009 ack  out  1  one-cycle completion pulse.
REQ-010 busy  out  1  high while a transaction is in progress.
REQ-011 rdata  out  4  last read word, true polarity.
REQ-012 mem_sel  out  16  one-hot row select to the cell array, active high.
REQ-013 mem_wri  out  1  write strobe to the cell array, active high.
REQ-014 mem_di  out  4  data to the cell array.
REQ-015 mem_do  in  4  wired-AND column outputs of the array, active-low (selected cell drives ~Q; unselected rows read 1).

Function
REQ-016 All outputs registered; mem_sel, mem_wri, mem_di glitch-free.
REQ-017 States: IDLE, SETUP, WRITE, HOLD, READ, DONE.
REQ-018 IDLE: mem_sel=0, mem_wri=0, mem_di=0, busy=0, ack=0; req=1 at an edge latches we/addr/wdata and enters SETUP.
REQ-019 SETUP (1 cycle): mem_sel=one-hot(addr), mem_di=wdata if write else 0, mem_wri=0; next WRITE if we else READ.
REQ-020 WRITE (WR_PULSE cycles): mem_wri=1, mem_sel and mem_di unchanged; then HOLD.
REQ-021 HOLD (1 cycle): mem_wri=0, mem_sel and mem_di unchanged; then DONE.
REQ-022 READ (RD_SETTLE cycles): mem_sel held, mem_wri=0; at the edge ending the last READ cycle rdata <= ~mem_do; then DONE.
REQ-023 DONE (1 cycle): ack=1, mem_sel=0, mem_wri=0, mem_di=0; then IDLE.
REQ-024 busy=1 in SETUP, WRITE, HOLD, READ, DONE.
REQ-025 Latency: write ack in cycle WR_PULSE+3 after accepting edge; read ack in cycle RD_SETTLE+2.
REQ-026 mem_wri never high unless mem_sel is one-hot with identical value for the cycle before, during, and after the pulse.
REQ-027 req while busy is ignored, not queued; req held high starts the next transaction at the edge leaving IDLE, giving one IDLE cycle with mem_sel=0 between transactions.
REQ-028 Changes to we/addr/wdata after acceptance have no effect on the current transaction.
REQ-029 rdata holds its value until the next read capture; writes never change rdata.
REQ-030 Internal cycle counter 4 bits wide, reloaded on entry to WRITE and READ.

Reset
REQ-031 reset=1 at an edge, in any state, forces IDLE: ack=0, busy=0, mem_sel=0, mem_wri=0, mem_di=0, rdata=0, counter=0.
REQ-032 reset has priority over req; req sampled with reset high is discarded.
REQ-033 A write interrupted by reset leaves the addressed word undefined; the controller makes no guarantee about array contents.

Verification
REQ-034 Reset, write addr=5 wdata=4'hA, then read addr=5 against a behavioural 16x4 array model -> write ack in cycle 5, read ack in cycle 4, rdata=4'hA.
REQ-035 Write addr=5 waveform check -> mem_sel=16'h0020 from SETUP through HOLD (4 cycles), mem_wri high exactly cycles 2-3, mem_di=4'hA throughout, all zero in DONE.
REQ-036 req held high, write addr=0 then addr=15 -> one IDLE cycle with mem_sel=0 between transactions; mem_sel goes 16'h0001 then 16'h8000; no overlap.
REQ-037 reset pulsed during second WRITE cycle -> next cycle mem_wri=0, mem_sel=0, busy=0, rdata=0; subsequent read of another address completes normally.
REQ-038 Read with mem_do forced to 4'b0101 during READ -> rdata=4'b1010 after ack; req toggled while busy is ignored.
REQ-039 WR_PULSE=1, RD_SETTLE=3 -> write ack in cycle 4, read ack in cycle 5, mem_wri high exactly 1 cycle.
